// File: rtl/prog_seq_detector_if.sv
// Bundle of serial data, config and status signals for prog_seq_detector.
// master drives din/config/cnt_clr; slave (the detector) drives dout/match_count/cfg_err.
interface prog_seq_detector_if #(
    parameter int MAX_LEN = 8,
    parameter int CNT_W   = 8
);
    localparam int LEN_W = $clog2(MAX_LEN + 1);

    logic               din;
    logic               din_valid;
    logic               cfg_load;
    logic [MAX_LEN-1:0] cfg_pattern;
    logic [LEN_W-1:0]   cfg_len;
    logic               cfg_overlap;
    logic               cnt_clr;
    logic               dout;
    logic [CNT_W-1:0]   match_count;
    logic               cfg_err;

    modport master (
        output din, din_valid, cfg_load, cfg_pattern,
        output cfg_len, cfg_overlap, cnt_clr,
        input  dout, match_count, cfg_err
    );

    modport slave (
        input  din, din_valid, cfg_load, cfg_pattern,
        input  cfg_len, cfg_overlap, cnt_clr,
        output dout, match_count, cfg_err
    );
endinterface

// File: rtl/prog_seq_detector.sv
// Programmable serial pattern detector (1..MAX_LEN bits, overlap selectable).
// Ports: clk, reset (async high), bus (slave): din/valid in, cfg_* in, dout/match_count/cfg_err out.
module prog_seq_detector #(
    parameter int                 MAX_LEN     = 8,
    parameter int                 CNT_W       = 8,
    parameter logic [MAX_LEN-1:0] RST_PATTERN = MAX_LEN'('b1010),
    parameter int                 RST_LEN     = 4,
    parameter bit                 RST_OVERLAP = 1'b1
) (
    input  logic               clk,
    input  logic               reset,
    prog_seq_detector_if.slave bus
);
    localparam int               LEN_W   = $clog2(MAX_LEN + 1);
    localparam logic [LEN_W-1:0] LEN_MAX = LEN_W'(MAX_LEN);

    logic [MAX_LEN-1:0] pattern_q, pattern_d;
    logic [LEN_W-1:0]   len_q, len_d;
    logic               overlap_q, overlap_d;
    logic               err_q, err_d;
    logic [MAX_LEN-1:0] hist_q, hist_d;
    logic [LEN_W-1:0]   fill_q, fill_d;
    logic               dout_q, dout_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;

    logic [LEN_W-1:0]   fill_inc;
    logic [MAX_LEN-1:0] mask;
    logic               hit;

    always_comb begin
        pattern_d = pattern_q;
        len_d     = len_q;
        overlap_d = overlap_q;
        err_d     = err_q;
        hist_d    = hist_q;
        fill_d    = fill_q;
        dout_d    = 1'b0;
        cnt_d     = cnt_q;
        fill_inc  = fill_q;
        hit       = 1'b0;

        // Only the low len bits of pattern/history take part in a compare.
        for (int i = 0; i < MAX_LEN; i++) begin
            mask[i] = (LEN_W'(i) < len_q);
        end

        if (bus.cfg_load) begin
            pattern_d = bus.cfg_pattern;
            len_d     = bus.cfg_len;
            overlap_d = bus.cfg_overlap;
            err_d     = (bus.cfg_len == '0) || (bus.cfg_len > LEN_MAX);
            fill_d    = '0;
        end else if (bus.din_valid) begin
            hist_d   = {hist_q[MAX_LEN-2:0], bus.din};
            fill_inc = (fill_q == LEN_MAX) ? fill_q : fill_q + LEN_W'(1);
            hit      = !err_q && (fill_inc >= len_q) &&
                       (((hist_d ^ pattern_q) & mask) == '0);
            // Non-overlap: forget the bits already consumed by this match.
            fill_d   = (hit && !overlap_q) ? '0 : fill_inc;
            dout_d   = hit;
        end

        if (bus.cnt_clr) begin
            cnt_d = '0;
        end else if (hit && (cnt_q != '1)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pattern_q <= RST_PATTERN;
            len_q     <= LEN_W'(RST_LEN);
            overlap_q <= RST_OVERLAP;
            err_q     <= 1'b0;
            hist_q    <= '0;
            fill_q    <= '0;
            dout_q    <= 1'b0;
            cnt_q     <= '0;
        end else begin
            pattern_q <= pattern_d;
            len_q     <= len_d;
            overlap_q <= overlap_d;
            err_q     <= err_d;
            hist_q    <= hist_d;
            fill_q    <= fill_d;
            dout_q    <= dout_d;
            cnt_q     <= cnt_d;
        end
    end

    assign bus.dout        = dout_q;
    assign bus.match_count = cnt_q;
    assign bus.cfg_err     = err_q;
endmodule

// File: tb/tb_prog_seq_detector.sv
// Bench for prog_seq_detector: queue-based reference model checked every cycle
// on two instances (CNT_W=8 and CNT_W=2) plus hand-computed expectations.
module tb_prog_seq_detector;
    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       din = 1'b0;
    logic       din_valid = 1'b0;
    logic       cfg_load = 1'b0;
    logic [7:0] cfg_pattern = 8'h00;
    logic [3:0] cfg_len = 4'd0;
    logic       cfg_overlap = 1'b0;
    logic       cnt_clr = 1'b0;

    int checks = 0;
    int errors = 0;
    int npulse = 0;
    int base = 0;
    bit chk_en = 1'b0;

    prog_seq_detector_if #(.MAX_LEN(8), .CNT_W(8)) bus_a ();
    prog_seq_detector_if #(.MAX_LEN(8), .CNT_W(2)) bus_b ();

    assign bus_a.din = din;
    assign bus_a.din_valid = din_valid;
    assign bus_a.cfg_load = cfg_load;
    assign bus_a.cfg_pattern = cfg_pattern;
    assign bus_a.cfg_len = cfg_len;
    assign bus_a.cfg_overlap = cfg_overlap;
    assign bus_a.cnt_clr = cnt_clr;
    assign bus_b.din = din;
    assign bus_b.din_valid = din_valid;
    assign bus_b.cfg_load = cfg_load;
    assign bus_b.cfg_pattern = cfg_pattern;
    assign bus_b.cfg_len = cfg_len;
    assign bus_b.cfg_overlap = cfg_overlap;
    assign bus_b.cnt_clr = cnt_clr;

    prog_seq_detector #(.MAX_LEN(8), .CNT_W(8)) dut_a (
        .clk(clk), .reset(reset), .bus(bus_a.slave)
    );
    prog_seq_detector #(.MAX_LEN(8), .CNT_W(2)) dut_b (
        .clk(clk), .reset(reset), .bus(bus_b.slave)
    );

    always #5 clk = ~clk;

    // Reference model: queue of bits accepted since the search restarted.
    logic [7:0] mpat = 8'b1010;
    int         mlen = 4;
    bit         movl = 1'b1;
    bit         merr = 1'b0;
    bit         mq[$];
    bit         mdout = 1'b0;
    int         mcnt_a = 0;
    int         mcnt_b = 0;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            mpat = 8'b1010;
            mlen = 4;
            movl = 1'b1;
            merr = 1'b0;
            mq.delete();
            mdout = 1'b0;
            mcnt_a = 0;
            mcnt_b = 0;
        end else begin
            bit m;
            m = 1'b0;
            if (cfg_load) begin
                mpat = cfg_pattern;
                mlen = int'(cfg_len);
                movl = cfg_overlap;
                merr = (cfg_len == 0) || (cfg_len > 8);
                mq.delete();
            end else if (din_valid) begin
                mq.push_back(din);
                if (mq.size() > 8) void'(mq.pop_front());
                if (!merr && mq.size() >= mlen) begin
                    m = 1'b1;
                    for (int k = 0; k < mlen; k++)
                        if (mq[mq.size() - 1 - k] != mpat[k]) m = 1'b0;
                end
                if (m && !movl) mq.delete();
            end
            mdout = m;
            if (cnt_clr) begin
                mcnt_a = 0;
                mcnt_b = 0;
            end else if (m) begin
                if (mcnt_a < 255) mcnt_a++;
                if (mcnt_b < 3) mcnt_b++;
            end
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            chk("dout_a", int'(bus_a.dout), int'(mdout));
            chk("dout_b", int'(bus_b.dout), int'(mdout));
            chk("count_a", int'(bus_a.match_count), mcnt_a);
            chk("count_b", int'(bus_b.match_count), mcnt_b);
            chk("err_a", int'(bus_a.cfg_err), int'(merr));
            chk("err_b", int'(bus_b.cfg_err), int'(merr));
            if (bus_a.dout) npulse++;
        end
    end

    task automatic step(input bit d, input bit v, input bit c = 1'b0);
        din = d;
        din_valid = v;
        cnt_clr = c;
        cfg_load = 1'b0;
        @(posedge clk);
        #1;
        din_valid = 1'b0;
        cnt_clr = 1'b0;
    endtask

    task automatic idle(input int n = 1);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0);
    endtask

    task automatic load(input logic [7:0] p, input logic [3:0] l,
                        input bit o);
        cfg_load = 1'b1;
        cfg_pattern = p;
        cfg_len = l;
        cfg_overlap = o;
        din = 1'b1;
        din_valid = 1'b1;
        @(posedge clk);
        #1;
        cfg_load = 1'b0;
        din_valid = 1'b0;
    endtask

    task automatic feed(input logic [15:0] bits, input int n);
        for (int i = n - 1; i >= 0; i--) step(bits[i], 1'b1);
    endtask

    initial begin
        #1 reset = 1'b1;
        #1 chk_en = 1'b1;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        chk("rst dout", int'(bus_a.dout), 0);
        chk("rst count", int'(bus_a.match_count), 0);
        chk("rst err", int'(bus_a.cfg_err), 0);

        // T1: reset config 1010 overlapping
        base = npulse;
        feed(16'b1010, 4);
        chk("t1 dout4", int'(bus_a.dout), 1);
        step(1'b1, 1'b1);
        chk("t1 dout5", int'(bus_a.dout), 0);
        step(1'b0, 1'b1);
        chk("t1 dout6", int'(bus_a.dout), 1);
        idle();
        chk("t1 pulses", npulse - base, 2);
        chk("t1 count", int'(bus_a.match_count), 2);

        // T2: non-overlapping
        step(1'b0, 1'b0, 1'b1);
        load(8'b1010, 4'd4, 1'b0);
        base = npulse;
        feed(16'b10101010, 8);
        chk("t2 dout8", int'(bus_a.dout), 1);
        idle();
        chk("t2 pulses", npulse - base, 2);
        chk("t2 count", int'(bus_a.match_count), 2);

        // T3: valid gaps
        load(8'b1010, 4'd4, 1'b1);
        base = npulse;
        step(1'b1, 1'b1);
        step(1'b1, 1'b0);
        step(1'b1, 1'b0);
        step(1'b1, 1'b0);
        step(1'b0, 1'b1);
        step(1'b1, 1'b1);
        step(1'b1, 1'b0);
        chk("t3 early", npulse - base, 0);
        step(1'b0, 1'b1);
        chk("t3 dout", int'(bus_a.dout), 1);
        idle();
        chk("t3 pulses", npulse - base, 1);
        chk("t3 count", int'(bus_a.match_count), 3);

        // T4: full length, then invalid lengths, then len=1
        load(8'b11010011, 4'd8, 1'b1);
        base = npulse;
        feed(16'b11010011, 8);
        chk("t4 dout8", int'(bus_a.dout), 1);
        idle();
        chk("t4 pulses", npulse - base, 1);
        load(8'h00, 4'd0, 1'b1);
        chk("t4 err0", int'(bus_a.cfg_err), 1);
        base = npulse;
        feed(16'b10110011, 8);
        idle();
        chk("t4 err pulses", npulse - base, 0);
        chk("t4 count", int'(bus_a.match_count), 4);
        load(8'hff, 4'd9, 1'b1);
        chk("t4 err9", int'(bus_a.cfg_err), 1);
        load(8'h01, 4'd1, 1'b0);
        chk("t4 err clr", int'(bus_a.cfg_err), 0);
        base = npulse;
        feed(16'b101, 3);
        idle();
        chk("t4 len1 pulses", npulse - base, 2);
        chk("t4 len1 count", int'(bus_a.match_count), 6);

        // T5: saturation on the 2-bit counter, clear beats match
        step(1'b0, 1'b0, 1'b1);
        load(8'b1010, 4'd4, 1'b1);
        base = npulse;
        feed(16'b101010101010, 12);
        idle();
        chk("t5 pulses", npulse - base, 5);
        chk("t5 count_a", int'(bus_a.match_count), 5);
        chk("t5 count_b", int'(bus_b.match_count), 3);
        feed(16'b101, 3);
        step(1'b0, 1'b1, 1'b1);
        chk("t5 clr dout", int'(bus_b.dout), 1);
        chk("t5 clr count_a", int'(bus_a.match_count), 0);
        chk("t5 clr count_b", int'(bus_b.match_count), 0);
        idle();

        // T6: reset mid-stream reverts config and discards history
        load(8'h01, 4'd1, 1'b1);
        feed(16'b101, 3);
        reset = 1'b1;
        #2;
        chk("t6 rst dout", int'(bus_a.dout), 0);
        chk("t6 rst count", int'(bus_a.match_count), 0);
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        base = npulse;
        step(1'b0, 1'b1);
        idle();
        chk("t6 no match", npulse - base, 0);
        feed(16'b1010, 4);
        chk("t6 dout", int'(bus_a.dout), 1);
        idle();
        chk("t6 pulses", npulse - base, 1);
        chk("t6 count", int'(bus_a.match_count), 1);

        idle(2);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
